slave_port_burst: RTL
=====================

# slave_port_burst

Parametrised serial bus slave port, successor to the fixed 12-bit-address / 8-bit-data slave port. It deserialises address, burst length and write data from the master's serial lines and drives a single-port BRAM-style memory interface. It serialises read data back under a valid/ready handshake and supports incrementing bursts and a read-response timeout. It sits between the system bus interconnect and one slave memory.

## Interface
- ADDR_WIDTH, 12, address bits per transaction.
- DATA_WIDTH, 8, data bits per beat.
- BURST_W, 3, burst-length field width; max beats = 2^BURST_W; requires BURST_W <= ADDR_WIDTH.
- TIMEOUT, 16, max cycles to wait for data_ready on a read beat; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- read_en / write_en  in  1 each  transaction type, sampled in IDLE.
- master_valid  in  1  master drives a valid bit on rx_address / rx_burst / rx_data.
- master_ready  in  1  master accepts the current tx_data bit.
- rx_address  in  1  serial address, LSB first.
- rx_burst  in  1  serial burst field (beats-1), LSB first, concurrent with the first BURST_W address bits.
- rx_data  in  1  serial write data, LSB first.
- slave_ready  out  1  slave accepts rx bits this cycle.
- slave_valid  out  1  tx_data holds a valid bit.
- tx_data  out  1  serial read data, LSB first.
- rx_done  out  1  one-cycle pulse when the last write beat is committed.
- slave_tx_done  out  1  one-cycle pulse after the last read bit transfers.
- err  out  1  one-cycle pulse on a protocol error or timeout.
- data_ready  in  1  memory read data valid on datain.
- datain  in  DATA_WIDTH  memory read data.
- address  out  ADDR_WIDTH  memory address.
- data  out  DATA_WIDTH  memory write data.
- read_en_bram / write_en_bram  out  1 each  memory strobes, one-cycle pulses.

## Operation
- States: IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, TX.
- A bit is accepted on a cycle where master_valid && slave_ready. slave_ready = 1 in IDLE, ADDR and WDATA; 0 otherwise.
- IDLE:
  - write_en xor read_en with master_valid: accept address bit 0 (and burst bit 0), latch the type, go to ADDR.
  - Both high: pulse err, stay in IDLE, accept nothing.
- ADDR: accept bits until ADDR_WIDTH bits are held. Then go to WDATA (write) or RREQ (read). Beat counter = 0.
- WDATA: accept DATA_WIDTH bits from rx_data, then go to WRITE.
- WRITE:
  - Pulse write_en_bram with address = base + beat and data = the assembled word.
  - If beat == burst field: pulse rx_done, go to IDLE.
  - Otherwise increment beat, go to WDATA.
- RREQ: pulse read_en_bram with address = base + beat, clear the timeout counter, go to RWAIT.
- RWAIT:
  - data_ready: latch datain into the shift register, go to TX.
  - No data_ready: the counter increments each cycle. At count == TIMEOUT, pulse err and go to IDLE.
- TX:
  - slave_valid = 1 and tx_data = shift register LSB. On master_ready, shift and count.
  - After DATA_WIDTH transfers: if beat == burst field, pulse slave_tx_done and go to IDLE; otherwise increment beat and go to RREQ.
- Address increment is modulo 2^ADDR_WIDTH; the burst wraps 0xFFF -> 0x000 at the default width.
- data_ready outside RWAIT is ignored. Input changes while not in IDLE are ignored for read_en / write_en.
- Asynchronous reset mid-transaction: immediate return to IDLE and all counters cleared. No strobe is issued for a partial beat.

## Timing
- Reset values:
  - slave_ready = 1.
  - All other outputs = 0, including address and data.
- Write: last data bit accepted in cycle N -> write_en_bram in N+1 (slave_ready = 0). The next beat's first bit is accepted from N+2.
- Read:
  - Last address bit in cycle N -> read_en_bram in N+1. data_ready is sampled from N+2.
  - data_ready in cycle M -> slave_valid = 1 from M+1.
- A TX bit with master_ready held high transfers every cycle. The final transfer in cycle K -> slave_tx_done in K+1, with slave_ready = 1 that cycle.
- Timeout: err fires exactly TIMEOUT cycles after entering RWAIT.
- address / data hold their last value between strobes.

## Test plan
- Single write, defaults: address 0x2A5, burst 0, data 0xC3, master_valid always 1 -> one write_en_bram with address = 0x2A5 and data = 0xC3, rx_done in the same cycle.
- Write burst of 4 from 0xFFE -> strobes at 0xFFE, 0xFFF, 0x000, 0x001 with the correct data; a single rx_done after the fourth.
- Read burst of 2 from 0x010, memory responds after 1 cycle with 0x5A then 0xA5, master_ready toggling -> tx_data carries 0x5A then 0xA5 LSB first; slave_tx_done once; no bit is lost while master_ready = 0.
- Read with data_ready never asserted, TIMEOUT = 16 -> err pulse 16 cycles after entering RWAIT, FSM returns to IDLE, slave_ready = 1.
- read_en and write_en both high with master_valid -> err pulse, no strobes; a following legal write completes normally.
- reset deasserted-to-asserted during the WDATA of beat 2 -> no write_en_bram for that beat; all outputs return to reset values immediately.

Source files
------------

// File: rtl/slave_port_burst_if.sv
// Serial master/slave bus plus single-port memory strobes for slave_port_burst.
// The master modport also carries the memory side so one bench agent can play both.
interface slave_port_burst_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  read_en;
  logic                  write_en;
  logic                  master_valid;
  logic                  master_ready;
  logic                  rx_address;
  logic                  rx_burst;
  logic                  rx_data;
  logic                  slave_ready;
  logic                  slave_valid;
  logic                  tx_data;
  logic                  rx_done;
  logic                  slave_tx_done;
  logic                  err;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] datain;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;
  logic                  read_en_bram;
  logic                  write_en_bram;

  modport slave (
    input  read_en, write_en, master_valid, master_ready,
    input  rx_address, rx_burst, rx_data, data_ready, datain,
    output slave_ready, slave_valid, tx_data, rx_done, slave_tx_done, err,
    output address, data, read_en_bram, write_en_bram
  );

  modport master (
    output read_en, write_en, master_valid, master_ready,
    output rx_address, rx_burst, rx_data, data_ready, datain,
    input  slave_ready, slave_valid, tx_data, rx_done, slave_tx_done, err,
    input  address, data, read_en_bram, write_en_bram
  );
endinterface

// File: rtl/slave_port_burst.sv
// Serial bus slave port: deserialises address/burst/write data into memory strobes
// and serialises memory read data back, with incrementing bursts and read timeout.
module slave_port_burst #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_W    = 3,
  parameter int TIMEOUT    = 16
) (
  input logic               clk,
  input logic               reset,
  slave_port_burst_if.slave bus
);
  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_RREQ, S_RWAIT, S_TX
  } state_t;

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr_sr, r_address, w_addr_full;
  logic [BURST_W-1:0]    r_burst, r_beat, w_burst_shift;
  logic [DATA_WIDTH-1:0] r_wdata_sr, r_tx_sr, r_data, w_wdata_full;
  logic [CW-1:0]         r_bit_cnt;
  logic [TW-1:0]         r_tmo_cnt;
  logic                  r_is_write, r_tx_done;
  logic                  w_slave_ready, w_slave_valid, w_err, w_wr_stb, w_rd_stb;
  logic                  w_rx_done, w_start, w_accept;
  logic                  w_addr_last, w_data_last, w_last_beat, w_timeout;

  // Fields arrive LSB first, so each new bit enters at the top and shifts down.
  assign w_addr_full   = (r_addr_sr >> 1) | (ADDR_WIDTH'(bus.rx_address) << (ADDR_WIDTH - 1));
  assign w_burst_shift = (r_burst >> 1) | (BURST_W'(bus.rx_burst) << (BURST_W - 1));
  assign w_wdata_full  = (r_wdata_sr >> 1) | (DATA_WIDTH'(bus.rx_data) << (DATA_WIDTH - 1));

  assign w_accept    = bus.master_valid && w_slave_ready;
  assign w_addr_last = (r_bit_cnt == CW'(ADDR_WIDTH - 1));
  assign w_data_last = (r_bit_cnt == CW'(DATA_WIDTH - 1));
  assign w_last_beat = (r_beat == r_burst);
  assign w_timeout   = (r_tmo_cnt == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_slave_ready = 1'b0;
    w_slave_valid = 1'b0;
    w_err         = 1'b0;
    w_wr_stb      = 1'b0;
    w_rd_stb      = 1'b0;
    w_rx_done     = 1'b0;
    w_start       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_slave_ready = 1'b1;
        if (bus.master_valid) begin
          if (bus.read_en && bus.write_en) begin
            w_err = 1'b1;
          end else if (bus.read_en ^ bus.write_en) begin
            w_start      = 1'b1;
            w_state_next = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        w_slave_ready = 1'b1;
        if (w_accept && w_addr_last) w_state_next = r_is_write ? S_WDATA : S_RREQ;
      end
      S_WDATA: begin
        w_slave_ready = 1'b1;
        if (w_accept && w_data_last) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        w_wr_stb = 1'b1;
        if (w_last_beat) begin
          w_rx_done    = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_WDATA;
        end
      end
      S_RREQ: begin
        w_rd_stb     = 1'b1;
        w_state_next = S_RWAIT;
      end
      S_RWAIT: begin
        // The timeout wins over a simultaneous data_ready: the wait window is exactly TIMEOUT cycles.
        if (w_timeout) begin
          w_err        = 1'b1;
          w_state_next = S_IDLE;
        end else if (bus.data_ready) begin
          w_state_next = S_TX;
        end
      end
      S_TX: begin
        w_slave_valid = 1'b1;
        if (bus.master_ready && w_data_last) w_state_next = w_last_beat ? S_IDLE : S_RREQ;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_sr  <= '0;
      r_address  <= '0;
      r_burst    <= '0;
      r_beat     <= '0;
      r_wdata_sr <= '0;
      r_tx_sr    <= '0;
      r_data     <= '0;
      r_bit_cnt  <= '0;
      r_tmo_cnt  <= '0;
      r_is_write <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= (r_state == S_TX) && bus.master_ready && w_data_last && w_last_beat;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_is_write <= bus.write_en;
          r_addr_sr  <= w_addr_full;
          r_burst    <= w_burst_shift;
          r_bit_cnt  <= CW'(1);
          r_beat     <= '0;
        end
        S_ADDR: if (w_accept) begin
          r_addr_sr <= w_addr_full;
          if (r_bit_cnt < CW'(BURST_W)) r_burst <= w_burst_shift;
          if (w_addr_last) begin
            r_bit_cnt <= '0;
            if (!r_is_write) r_address <= w_addr_full;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        S_WDATA: if (w_accept) begin
          r_wdata_sr <= w_wdata_full;
          if (w_data_last) begin
            r_bit_cnt <= '0;
            r_data    <= w_wdata_full;
            r_address <= r_addr_sr + ADDR_WIDTH'(r_beat);
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        S_WRITE: if (!w_last_beat) r_beat <= r_beat + BURST_W'(1);
        S_RREQ:  r_tmo_cnt <= '0;
        S_RWAIT: if (!w_timeout) begin
          if (bus.data_ready) begin
            r_tx_sr   <= bus.datain;
            r_bit_cnt <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end
        S_TX: if (bus.master_ready) begin
          r_tx_sr <= r_tx_sr >> 1;
          if (w_data_last) begin
            r_bit_cnt <= '0;
            if (!w_last_beat) begin
              r_beat    <= r_beat + BURST_W'(1);
              r_address <= r_addr_sr + ADDR_WIDTH'(r_beat) + ADDR_WIDTH'(1);
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.slave_ready   = w_slave_ready;
  assign bus.slave_valid   = w_slave_valid;
  assign bus.tx_data       = w_slave_valid & r_tx_sr[0];
  assign bus.rx_done       = w_rx_done;
  assign bus.slave_tx_done = r_tx_done;
  assign bus.err           = w_err;
  assign bus.address       = r_address;
  assign bus.data          = r_data;
  assign bus.read_en_bram  = w_rd_stb;
  assign bus.write_en_bram = w_wr_stb;
endmodule
